// File: rtl/regfile_pkg.sv
// Shared constants and bus helpers for the multi-port MIPS register file.
package regfile_pkg;

    localparam int DEF_DW     = 32;
    localparam int DEF_AW     = 5;
    localparam int REG_ZERO   = 0;

    // Widest port and widest flat bus the unpack helper handles (4 ports x 64 bits).
    localparam int PORT_MAX_W = 64;
    localparam int BUS_MAX_W  = 4 * PORT_MAX_W;

    // Extract field idx of width w from a flat bus packed as [idx*w +: w].
    function automatic logic [PORT_MAX_W-1:0] unpack_port(input logic [BUS_MAX_W-1:0] flat,
                                                          input int idx,
                                                          input int w);
        logic [BUS_MAX_W-1:0]  sh;
        logic [PORT_MAX_W-1:0] mask;
        sh   = flat >> (idx * w);
        mask = (w >= PORT_MAX_W) ? '1 : ((PORT_MAX_W'(1) << w) - PORT_MAX_W'(1));
        return sh[PORT_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback bus of the multi-port register file: read ports, two retire lanes, reserve.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW,
    parameter int NR = 2
);
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    rd_busy;
    logic             we0;
    logic [AW-1:0]    wa0;
    logic [DW-1:0]    wd0;
    logic             we1;
    logic [AW-1:0]    wa1;
    logic [DW-1:0]    wd1;
    logic             rsv_en;
    logic [AW-1:0]    rsv_a;

    modport master (
        output ra, we0, wa0, wd0, we1, wa1, wd1, rsv_en, rsv_a,
        input  rd, rd_busy
    );

    modport slave (
        input  ra, we0, wa0, wd0, we1, wa1, wd1, rsv_en, rsv_a,
        output rd, rd_busy
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy vector: decode reserves a destination, either retire lane releases it.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int NR      = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we0,
    input  logic [AW-1:0]    wa0,
    input  logic             we1,
    input  logic [AW-1:0]    wa1,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_a,
    input  logic [NR*AW-1:0] ra,
    output logic [NR-1:0]    rd_busy
);
    localparam int DEPTH = 2 ** AW;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;

    // Retiring writes clear first so a same-cycle reserve (newer producer) wins.
    always_comb begin
        busy_nxt = busy;
        if (we0) busy_nxt[wa0] = 1'b0;
        if (we1) busy_nxt[wa1] = 1'b0;
        if (rsv_en && !(ZERO_R0 != 0 && rsv_a == AW'(REG_ZERO))) busy_nxt[rsv_a] = 1'b1;
        if (ZERO_R0 != 0) busy_nxt[REG_ZERO] = 1'b0;
    end

    // Busy vector register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_nxt;
    end

    // A write hitting the read address this cycle hides busy so the consumer takes the bypass.
    for (genvar g = 0; g < NR; g++) begin : g_busy
        logic [AW-1:0] a;
        assign a = AW'(unpack_port(BUS_MAX_W'(ra), g, AW));
        assign rd_busy[g] = busy[a] & ~((we0 && wa0 == a) || (we1 && wa1 == a));
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: data array, two prioritised write lanes, bypassed combinational reads.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int AW      = DEF_AW,
    parameter int NR      = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0]    mem [DEPTH];
    logic [NR*DW-1:0] rd_flat;

    // Array update; lane 1 is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else begin
            if (bus.we0 && !(ZERO_R0 != 0 && bus.wa0 == AW'(REG_ZERO))) mem[bus.wa0] <= bus.wd0;
            if (bus.we1 && !(ZERO_R0 != 0 && bus.wa1 == AW'(REG_ZERO))) mem[bus.wa1] <= bus.wd1;
        end
    end

    for (genvar g = 0; g < NR; g++) begin : g_rd
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        assign a = AW'(unpack_port(BUS_MAX_W'(bus.ra), g, AW));

        // Read mux, lowest priority first: array, lane 0, lane 1, hardwired zero.
        always_comb begin
            v = mem[a];
            if (bus.we0 && bus.wa0 == a) v = bus.wd0;
            if (bus.we1 && bus.wa1 == a) v = bus.wd1;
            if (ZERO_R0 != 0 && a == AW'(REG_ZERO)) v = '0;
        end

        assign rd_flat[g*DW +: DW] = v;
    end

    assign bus.rd = rd_flat;

    regfile_scoreboard #(
        .AW      (AW),
        .NR      (NR),
        .ZERO_R0 (ZERO_R0)
    ) u_scoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .we0     (bus.we0),
        .wa0     (bus.wa0),
        .we1     (bus.we1),
        .wa1     (bus.wa1),
        .rsv_en  (bus.rsv_en),
        .rsv_a   (bus.rsv_a),
        .ra      (bus.ra),
        .rd_busy (bus.rd_busy)
    );

endmodule
